// File: rtl/gt_pll_reset_seq.sv
// gt_pll_reset_seq
//   Power-up/reset sequencer for one GTPE2_COMMON PLL (one instance per PLL).
//   Holds the PLL in power-down, pulses reset, waits for lock with a timeout
//   and retry budget, then qualifies lock stability before flagging ready.
//   Any lock or refclk loss re-sequences from reset.
//
// Ports
//   clk             in   sequencer clock (also feeds PLLxLOCKDETCLK)
//   rst_n           in   asynchronous active-low reset
//   enable          in   level: 1 = bring PLL up, 0 = power it down
//   pll_lock        in   PLLxLOCK, asynchronous to clk
//   pll_refclklost  in   PLLxREFCLKLOST, asynchronous to clk
//   pll_pd          out  to PLLxPD
//   pll_reset       out  to PLLxRESET
//   pll_ready       out  PLL locked and qualified
//   pll_fail        out  retry budget exhausted
//   lock_lost       out  sticky: lock or refclk lost while ready
//   retry_cnt       out  retry events since last ready / enable low
//   state           out  current state encoding (debug)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PD     0  | power-down held for PD_CYCLES once enable is seen
// RST    1  | PLL reset asserted with PD low for RESET_CYCLES
// WAIT   2  | waiting for synced lock, bounded by LOCK_TIMEOUT
// STABLE 3  | lock must hold LOCK_STABLE consecutive cycles
// READY  4  | PLL qualified; loss sets lock_lost and retries
// FAIL   5  | retry budget exhausted; terminal until enable drops

module gt_pll_reset_seq #(
  parameter int PD_CYCLES    = 64,
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRY    = 7,
  parameter int RW           = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          pll_lock,
  input  logic          pll_refclklost,
  output logic          pll_pd,
  output logic          pll_reset,
  output logic          pll_ready,
  output logic          pll_fail,
  output logic          lock_lost,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    ST_PD     = 3'd0,
    ST_RST    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STABLE = 3'd3,
    ST_READY  = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  localparam logic [31:0]   PD_LAST     = 32'(PD_CYCLES - 1);
  localparam logic [31:0]   RESET_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0]   STABLE_LAST = 32'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  logic lock_meta_q, lock_s_q;
  logic lost_meta_q, lost_s_q;

  state_e        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          lock_lost_q, lock_lost_d;
  logic          retry_ev;

  // Two-flop synchronizers for the asynchronous PLL status inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      lost_meta_q <= 1'b0;
      lost_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      lost_meta_q <= pll_refclklost;
      lost_s_q    <= lost_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PD;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    retry_ev    = 1'b0;

    unique case (state_q)
      ST_PD: begin
        if (cnt_q == PD_LAST) state_d = ST_RST;
      end
      ST_RST: begin
        if (cnt_q == RESET_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Refclk loss outranks lock; lock outranks the timeout.
        if (lost_s_q)                   retry_ev = 1'b1;
        else if (lock_s_q)              state_d  = ST_STABLE;
        else if (cnt_q == TIMEOUT_LAST) retry_ev = 1'b1;
      end
      ST_STABLE: begin
        // A drop on the final count still retries rather than qualifying.
        if (!lock_s_q || lost_s_q) retry_ev = 1'b1;
        else if (cnt_q == STABLE_LAST) begin
          state_d = ST_READY;
          retry_d = '0;
        end
      end
      ST_READY: begin
        cnt_d = cnt_q;
        if (!lock_s_q || lost_s_q) begin
          lock_lost_d = 1'b1;
          retry_ev    = 1'b1;
        end
      end
      ST_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_PD;
      end
    endcase

    // Several simultaneous causes collapse into a single retry event.
    if (retry_ev) begin
      if (retry_q == RETRY_MAX) begin
        state_d = ST_FAIL;
      end else begin
        retry_d = retry_q + RW'(1);
        state_d = ST_RST;
      end
    end

    if (state_d != state_q) cnt_d = '0;

    if (!enable) begin
      state_d     = ST_PD;
      cnt_d       = '0;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end
  end

  assign pll_pd    = (state_q == ST_PD) || (state_q == ST_FAIL);
  assign pll_reset = (state_q == ST_PD) || (state_q == ST_RST) || (state_q == ST_FAIL);
  assign pll_ready = (state_q == ST_READY);
  assign pll_fail  = (state_q == ST_FAIL);
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_gt_pll_reset_seq.sv
module tb_gt_pll_reset_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_refclklost = 1'b0;
  logic       pll_pd, pll_reset, pll_ready, pll_fail, lock_lost;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int tcount  = 0;
  int rst_entries = 0;

  gt_pll_reset_seq #(
    .PD_CYCLES(4), .RESET_CYCLES(3), .LOCK_TIMEOUT(20),
    .LOCK_STABLE(5), .MAX_RETRY(2), .RW(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pll_lock(pll_lock),
    .pll_refclklost(pll_refclklost), .pll_pd(pll_pd), .pll_reset(pll_reset),
    .pll_ready(pll_ready), .pll_fail(pll_fail), .lock_lost(lock_lost),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       lock;
    logic       lost;
    logic       pd;
    logic       rst;
    logic       rdy;
    logic [2:0] st;
    logic [1:0] rc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (t=%0d): got %0d expected %0d", name, tcount, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcount++;
  endtask

  task automatic run_to(input int t);
    logic [2:0] prev;
    while (tcount < t) begin
      prev = state;
      tick();
      if (state == 3'd1 && prev != 3'd1) rst_entries++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    pll_lock = 1'b0;
    pll_refclklost = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tcount = 0;
    rst_entries = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Bring-up, lock from before edge 5: PD for edges 1-3, RST after 4-6,
    // WAIT after 7, lock_s seen at 8 -> STABLE, 5 stable samples (9-13) -> READY.
    //            en    lock  lost  pd    rst   rdy   st    rc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 2'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 2'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 2'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 2'd0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 2'd0};

    // Reset values
    do_reset();
    check("rst_pd",    pll_pd, 1);
    check("rst_reset", pll_reset, 1);
    check("rst_ready", pll_ready, 0);
    check("rst_fail",  pll_fail, 0);
    check("rst_lost",  lock_lost, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_state", state, 0);

    // 1: table-driven bring-up
    for (int i = 0; i < 14; i++) begin
      enable = vecs[i].en;
      pll_lock = vecs[i].lock;
      pll_refclklost = vecs[i].lost;
      tick();
      check($sformatf("v%0d_state", i), state, vecs[i].st);
      check($sformatf("v%0d_pd", i), pll_pd, vecs[i].pd);
      check($sformatf("v%0d_reset", i), pll_reset, vecs[i].rst);
      check($sformatf("v%0d_ready", i), pll_ready, vecs[i].rdy);
      check($sformatf("v%0d_retry", i), retry_cnt, vecs[i].rc);
    end

    // 2: no lock ever. WAIT after 7, timeouts at 27, 50, 73 (3rd -> FAIL).
    do_reset();
    enable = 1'b1;
    run_to(26);
    check("nl_state26", state, 2);
    check("nl_retry26", retry_cnt, 0);
    run_to(27);
    check("nl_state27", state, 1);
    check("nl_retry27", retry_cnt, 1);
    check("nl_reset27", pll_reset, 1);
    run_to(50);
    check("nl_state50", state, 1);
    check("nl_retry50", retry_cnt, 2);
    run_to(72);
    check("nl_state72", state, 2);
    check("nl_fail72",  pll_fail, 0);
    run_to(73);
    check("nl_state73", state, 5);
    check("nl_fail73",  pll_fail, 1);
    check("nl_pd73",    pll_pd, 1);
    check("nl_reset73", pll_reset, 1);
    check("nl_retry73", retry_cnt, 2);
    check("nl_rst_pulses", rst_entries, 3);
    run_to(80);
    check("nl_fail_hold", pll_fail, 1);
    enable = 1'b0;
    tick();
    check("nl_dis_state", state, 0);
    check("nl_dis_fail",  pll_fail, 0);
    check("nl_dis_retry", retry_cnt, 0);

    // 3: lock drops during STABLE; the drop lands on the final stable count.
    do_reset();
    enable = 1'b1;
    pll_lock = 1'b1;
    run_to(10);
    pll_lock = 1'b0;
    run_to(12);
    check("dr_state12", state, 3);
    run_to(13);
    check("dr_state13", state, 1);
    check("dr_retry13", retry_cnt, 1);
    check("dr_ready13", pll_ready, 0);
    run_to(15);
    pll_lock = 1'b1;
    run_to(22);
    check("dr_state22", state, 3);
    check("dr_retry22", retry_cnt, 1);
    run_to(23);
    check("dr_state23", state, 4);
    check("dr_ready23", pll_ready, 1);
    check("dr_retry23", retry_cnt, 0);
    check("dr_lost23",  lock_lost, 0);

    // 4: one-cycle lock glitch while READY
    run_to(25);
    pll_lock = 1'b0;
    run_to(26);
    pll_lock = 1'b1;
    run_to(27);
    check("gl_ready27", pll_ready, 1);
    check("gl_lost27",  lock_lost, 0);
    run_to(28);
    check("gl_ready28", pll_ready, 0);
    check("gl_lost28",  lock_lost, 1);
    check("gl_retry28", retry_cnt, 1);
    check("gl_state28", state, 1);
    run_to(36);
    check("gl_state36", state, 3);
    check("gl_lost36",  lock_lost, 1);
    run_to(37);
    check("gl_ready37", pll_ready, 1);
    check("gl_retry37", retry_cnt, 0);
    check("gl_lost37",  lock_lost, 1);

    // 5a: refclk lost in WAIT retries after sync latency, not at timeout
    do_reset();
    enable = 1'b1;
    run_to(9);
    pll_refclklost = 1'b1;
    run_to(11);
    check("rl_state11", state, 2);
    run_to(12);
    check("rl_state12", state, 1);
    check("rl_retry12", retry_cnt, 1);
    pll_refclklost = 1'b0;
    run_to(17);
    check("rl_state17", state, 2);
    // 5b: enable low mid-WAIT
    enable = 1'b0;
    run_to(18);
    check("en_state18", state, 0);
    check("en_pd18",    pll_pd, 1);
    check("en_reset18", pll_reset, 1);
    check("en_retry18", retry_cnt, 0);

    // 5c: async reset mid-STABLE, then clean restart
    do_reset();
    enable = 1'b1;
    pll_lock = 1'b1;
    run_to(10);
    check("ar_state10", state, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_state", state, 0);
    check("ar_pd",    pll_pd, 1);
    check("ar_reset", pll_reset, 1);
    check("ar_ready", pll_ready, 0);
    check("ar_fail",  pll_fail, 0);
    check("ar_retry", retry_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tcount = 0;
    run_to(12);
    check("ar_restart12", state, 3);
    run_to(13);
    check("ar_restart13", state, 4);
    check("ar_ready13", pll_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
